// File: rtl/eu_speriph_plug_arbiter.sv
// eu_speriph_plug_arbiter
//   Merges NB_PLUGS slave-peripheral plugs into the single speriph slave port
//   of the event unit. A round-robin arbiter picks one requesting plug and
//   passes its request fields through. Granted plug indices are recorded in an
//   in-flight FIFO so that in-order responses are routed back to their origin.
//
// Ports
//   clk_i, rst_i            clock, asynchronous active-high reset
//   s_req_i .. s_id_i       per-plug request fields (flattened, plug 0 in LSBs)
//   s_gnt_o                 per-plug grant (at most one bit set)
//   s_r_valid_o .. s_r_id_o per-plug response (zero for non-target plugs)
//   m_req_o .. m_id_o       merged request towards the event unit
//   m_gnt_i                 event unit grant
//   m_r_valid_i .. m_r_id_i event unit response
//   resp_err_o              sticky flag: response seen with nothing in flight
module eu_speriph_plug_arbiter #(
    parameter int NB_PLUGS    = 2,
    parameter int ID_WIDTH    = 5,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int OUTST_DEPTH = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NB_PLUGS-1:0]            s_req_i,
    input  logic [NB_PLUGS*ADDR_WIDTH-1:0] s_add_i,
    input  logic [NB_PLUGS-1:0]            s_wen_i,
    input  logic [NB_PLUGS*DATA_WIDTH-1:0] s_wdata_i,
    input  logic [NB_PLUGS*DATA_WIDTH/8-1:0] s_be_i,
    input  logic [NB_PLUGS*ID_WIDTH-1:0]   s_id_i,
    output logic [NB_PLUGS-1:0]            s_gnt_o,
    output logic [NB_PLUGS-1:0]            s_r_valid_o,
    output logic [NB_PLUGS*DATA_WIDTH-1:0] s_r_rdata_o,
    output logic [NB_PLUGS-1:0]            s_r_opc_o,
    output logic [NB_PLUGS*ID_WIDTH-1:0]   s_r_id_o,
    output logic                           m_req_o,
    output logic [ADDR_WIDTH-1:0]          m_add_o,
    output logic                           m_wen_o,
    output logic [DATA_WIDTH-1:0]          m_wdata_o,
    output logic [DATA_WIDTH/8-1:0]        m_be_o,
    output logic [ID_WIDTH-1:0]            m_id_o,
    input  logic                           m_gnt_i,
    input  logic                           m_r_valid_i,
    input  logic [DATA_WIDTH-1:0]          m_r_rdata_i,
    input  logic                           m_r_opc_i,
    input  logic [ID_WIDTH-1:0]            m_r_id_i,
    output logic                           resp_err_o
);

    localparam int PTR_W = $clog2(NB_PLUGS);
    localparam int FP_W  = (OUTST_DEPTH > 1) ? $clog2(OUTST_DEPTH) : 1;
    localparam int CNT_W = $clog2(OUTST_DEPTH + 1);
    localparam int BE_W  = DATA_WIDTH / 8;

    logic [PTR_W-1:0] rr_ptr_r;
    logic [PTR_W-1:0] idx_mem_r [OUTST_DEPTH];
    logic [FP_W-1:0]  wr_ptr_r;
    logic [FP_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             resp_err_r;

    logic [PTR_W-1:0] sel_s;
    logic [PTR_W-1:0] next_rr_s;
    logic [PTR_W-1:0] head_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic             m_req_s;
    logic             push_s;
    logic             pop_s;

    // FIFO pointer increment with wrap at OUTST_DEPTH
    function automatic logic [FP_W-1:0] fifo_inc(input logic [FP_W-1:0] p);
        if (p == FP_W'(OUTST_DEPTH - 1)) begin
            return '0;
        end else begin
            return p + FP_W'(1);
        end
    endfunction

    // Round-robin select: scan from rr_ptr upwards; the lowest offset wins
    always_comb begin
        logic [PTR_W-1:0] cand_v;
        sel_s  = '0;
        cand_v = '0;
        for (int i = NB_PLUGS - 1; i >= 0; i--) begin
            cand_v = PTR_W'((int'(rr_ptr_r) + i) % NB_PLUGS);
            if (s_req_i[cand_v]) begin
                sel_s = cand_v;
            end else begin
                sel_s = sel_s;
            end
        end
        if (sel_s == PTR_W'(NB_PLUGS - 1)) begin
            next_rr_s = '0;
        end else begin
            next_rr_s = sel_s + PTR_W'(1);
        end
    end

    // Request side: full FIFO blocks new grants even if a pop is happening
    always_comb begin
        fifo_full_s  = (count_r == CNT_W'(OUTST_DEPTH));
        fifo_empty_s = (count_r == '0);
        m_req_s      = (|s_req_i) & ~fifo_full_s & ~rst_i;
        push_s       = m_req_s & m_gnt_i;
        pop_s        = m_r_valid_i & ~fifo_empty_s & ~rst_i;
        head_s       = idx_mem_r[rd_ptr_r];
        m_req_o      = m_req_s;
        m_add_o      = s_add_i[sel_s*ADDR_WIDTH +: ADDR_WIDTH];
        m_wen_o      = s_wen_i[sel_s];
        m_wdata_o    = s_wdata_i[sel_s*DATA_WIDTH +: DATA_WIDTH];
        m_be_o       = s_be_i[sel_s*BE_W +: BE_W];
        m_id_o       = s_id_i[sel_s*ID_WIDTH +: ID_WIDTH];
        resp_err_o   = resp_err_r;
    end

    // Per-plug grant and response routing to the FIFO head
    always_comb begin
        s_gnt_o     = '0;
        s_r_valid_o = '0;
        s_r_rdata_o = '0;
        s_r_opc_o   = '0;
        s_r_id_o    = '0;
        for (int p = 0; p < NB_PLUGS; p++) begin
            if (push_s && (sel_s == PTR_W'(p))) begin
                s_gnt_o[p] = 1'b1;
            end else begin
                s_gnt_o[p] = 1'b0;
            end
            if (pop_s && (head_s == PTR_W'(p))) begin
                s_r_valid_o[p]                         = 1'b1;
                s_r_rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = m_r_rdata_i;
                s_r_opc_o[p]                           = m_r_opc_i;
                s_r_id_o[p*ID_WIDTH +: ID_WIDTH]       = m_r_id_i;
            end else begin
                s_r_valid_o[p] = 1'b0;
            end
        end
    end

    // Round-robin pointer: advances past the granted plug on each handshake
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_r <= '0;
        end else if (push_s) begin
            rr_ptr_r <= next_rr_s;
        end
    end

    // In-flight index FIFO; simultaneous push/pop keeps occupancy
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            for (int k = 0; k < OUTST_DEPTH; k++) begin
                idx_mem_r[k] <= '0;
            end
        end else begin
            if (push_s) begin
                idx_mem_r[wr_ptr_r] <= sel_s;
                wr_ptr_r            <= fifo_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= fifo_inc(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky error for a response arriving with nothing in flight
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            resp_err_r <= 1'b0;
        end else if (m_r_valid_i && fifo_empty_s) begin
            resp_err_r <= 1'b1;
        end
    end

endmodule

// File: tb/tb_eu_speriph_plug_arbiter.sv
module tb_eu_speriph_plug_arbiter;

    localparam logic [31:0] A0 = 32'h1000_0000;
    localparam logic [31:0] A1 = 32'h2000_0004;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [1:0]  s_req_i = 2'b00;
    logic [63:0] s_add_i;
    logic [1:0]  s_wen_i;
    logic [63:0] s_wdata_i;
    logic [7:0]  s_be_i;
    logic [9:0]  s_id_i;
    logic [1:0]  s_gnt_o;
    logic [1:0]  s_r_valid_o;
    logic [63:0] s_r_rdata_o;
    logic [1:0]  s_r_opc_o;
    logic [9:0]  s_r_id_o;
    logic        m_req_o;
    logic [31:0] m_add_o;
    logic        m_wen_o;
    logic [31:0] m_wdata_o;
    logic [3:0]  m_be_o;
    logic [4:0]  m_id_o;
    logic        m_gnt_i = 1'b0;
    logic        m_r_valid_i = 1'b0;
    logic [31:0] m_r_rdata_i = 32'h0;
    logic        m_r_opc_i = 1'b0;
    logic [4:0]  m_r_id_i = 5'h0;
    logic        resp_err_o;

    int n_cmp = 0;
    int n_bad = 0;

    eu_speriph_plug_arbiter dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .s_req_i(s_req_i), .s_add_i(s_add_i), .s_wen_i(s_wen_i),
        .s_wdata_i(s_wdata_i), .s_be_i(s_be_i), .s_id_i(s_id_i),
        .s_gnt_o(s_gnt_o), .s_r_valid_o(s_r_valid_o), .s_r_rdata_o(s_r_rdata_o),
        .s_r_opc_o(s_r_opc_o), .s_r_id_o(s_r_id_o),
        .m_req_o(m_req_o), .m_add_o(m_add_o), .m_wen_o(m_wen_o),
        .m_wdata_o(m_wdata_o), .m_be_o(m_be_o), .m_id_o(m_id_o),
        .m_gnt_i(m_gnt_i), .m_r_valid_i(m_r_valid_i), .m_r_rdata_i(m_r_rdata_i),
        .m_r_opc_i(m_r_opc_i), .m_r_id_i(m_r_id_i), .resp_err_o(resp_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        rst;
        logic [1:0]  req;
        logic        gnt;
        logic        rv;
        logic        exp_mreq;
        logic [1:0]  exp_gnt;
        logic [1:0]  exp_rv;
        logic        exp_err;
        logic [31:0] exp_add;
    } vec_t;

    vec_t vecs [19];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock; inputs change 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        s_add_i   = {A1, A0};
        s_wen_i   = 2'b10;
        s_wdata_i = {32'hBBBB_2222, 32'hAAAA_1111};
        s_be_i    = {4'hC, 4'h3};
        s_id_i    = {5'h12, 5'h03};

        //          rst   req    gnt   rv    mreq  gnt    rv     err   add
        vecs[0]  = '{1'b1, 2'b11, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, A0}; // reset
        vecs[1]  = '{1'b0, 2'b11, 1'b1, 1'b0, 1'b1, 2'b01, 2'b00, 1'b0, A0}; // fairness
        vecs[2]  = '{1'b0, 2'b11, 1'b1, 1'b1, 1'b1, 2'b10, 2'b01, 1'b0, A1};
        vecs[3]  = '{1'b0, 2'b11, 1'b1, 1'b1, 1'b1, 2'b01, 2'b10, 1'b0, A0};
        vecs[4]  = '{1'b0, 2'b11, 1'b1, 1'b1, 1'b1, 2'b10, 2'b01, 1'b0, A1};
        vecs[5]  = '{1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 2'b10, 1'b0, A0};
        vecs[6]  = '{1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 2'b01, 2'b00, 1'b0, A0}; // full
        vecs[7]  = '{1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 2'b01, 2'b00, 1'b0, A0};
        vecs[8]  = '{1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, A0};
        vecs[9]  = '{1'b0, 2'b01, 1'b1, 1'b1, 1'b0, 2'b00, 2'b01, 1'b0, A0};
        vecs[10] = '{1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 2'b01, 2'b00, 1'b0, A0};
        vecs[11] = '{1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 2'b01, 1'b0, A0};
        vecs[12] = '{1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 2'b01, 1'b0, A0};
        vecs[13] = '{1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, A0}; // spurious
        vecs[14] = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, A0};
        vecs[15] = '{1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 2'b01, 2'b00, 1'b1, A0}; // rr -> 1
        vecs[16] = '{1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, A0}; // mid-op reset
        vecs[17] = '{1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, A0};
        vecs[18] = '{1'b0, 2'b11, 1'b1, 1'b0, 1'b1, 2'b01, 2'b00, 1'b1, A0}; // rr back at 0

        for (int i = 0; i < 19; i++) begin
            rst_i       = vecs[i].rst;
            s_req_i     = vecs[i].req;
            m_gnt_i     = vecs[i].gnt;
            m_r_valid_i = vecs[i].rv;
            #1;
            check($sformatf("v%0d m_req", i), 64'(m_req_o), 64'(vecs[i].exp_mreq));
            check($sformatf("v%0d s_gnt", i), 64'(s_gnt_o), 64'(vecs[i].exp_gnt));
            check($sformatf("v%0d s_r_valid", i), 64'(s_r_valid_o), 64'(vecs[i].exp_rv));
            check($sformatf("v%0d resp_err", i), 64'(resp_err_o), 64'(vecs[i].exp_err));
            check($sformatf("v%0d m_add", i), 64'(m_add_o), 64'(vecs[i].exp_add));
            tick();
        end

        // Drain the plug-0 entry left by the last vector (rr now 1)
        s_req_i = 2'b00; m_gnt_i = 1'b0; m_r_valid_i = 1'b1;
        #1;
        check("drain r_valid", 64'(s_r_valid_o), 64'(2'b01));
        tick();

        // Routing: plug1 read with id 5'h12, response one cycle later
        s_req_i = 2'b10; m_gnt_i = 1'b1; m_r_valid_i = 1'b0;
        #1;
        check("route gnt", 64'(s_gnt_o), 64'(2'b10));
        check("route m_id", 64'(m_id_o), 64'(5'h12));
        check("route m_wen", 64'(m_wen_o), 64'(1'b1));
        check("route m_wdata", 64'(m_wdata_o), 64'(32'hBBBB_2222));
        check("route m_be", 64'(m_be_o), 64'(4'hC));
        tick();
        s_req_i = 2'b00; m_gnt_i = 1'b0; m_r_valid_i = 1'b1;
        m_r_rdata_i = 32'hCAFE_0001; m_r_id_i = 5'h12; m_r_opc_i = 1'b1;
        #1;
        check("route r_valid", 64'(s_r_valid_o), 64'(2'b10));
        check("route rdata1", 64'(s_r_rdata_o[63:32]), 64'(32'hCAFE_0001));
        check("route rdata0", 64'(s_r_rdata_o[31:0]), 64'(32'h0));
        check("route r_id", 64'(s_r_id_o), 64'({5'h12, 5'h00}));
        check("route opc", 64'(s_r_opc_o), 64'(2'b10));
        tick();
        m_r_valid_i = 1'b0; m_r_opc_i = 1'b0;

        // Plug0 fields pass through when plug0 alone requests (rr at 0)
        s_req_i = 2'b01; m_gnt_i = 1'b0;
        #1;
        check("p0 m_id", 64'(m_id_o), 64'(5'h03));
        check("p0 m_wen", 64'(m_wen_o), 64'(1'b0));
        check("p0 m_wdata", 64'(m_wdata_o), 64'(32'hAAAA_1111));
        check("p0 no gnt", 64'(s_gnt_o), 64'(2'b00));
        check("p0 m_req", 64'(m_req_o), 64'(1'b1));
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
